// File: rtl/fetch_queue_pkg.sv
// Shared types for the fetch queue: instruction word type and line word extraction.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package FetchQueueTypes;

  localparam int INSN_WIDTH = 32;

  // Upper bound on line width accepted by line_word; callers zero-extend
  // their line to this width so the helper stays parameter-independent.
  localparam int MAX_LINE_WIDTH = 1024;

  typedef logic [INSN_WIDTH-1:0] insn_t;

  // Word idx of a line, word 0 in the least significant bits.
  function automatic insn_t line_word(input logic [MAX_LINE_WIDTH-1:0] line,
                                      input int unsigned idx);
    return line[idx*INSN_WIDTH +: INSN_WIDTH];
  endfunction

endpackage

// File: rtl/fetch_queue_ram.sv
// Entry storage for the fetch queue: DEPTH registers, one write port, async read.
// Latency: write visible on the read port the cycle after the write edge.
// Backpressure: none; the owner only writes slots it knows are free.
// Ports: clk/rst_n clock and async active-low reset (clears contents);
//        we/waddr/wdata write port; raddr/rdata combinational read port.
module fetch_queue_ram #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 161,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Decoupling queue of fetched i-cache lines, handed out one instruction word per handshake.
// Latency: a line enqueued at edge N is presented at N+1 (no combinational bypass).
// Backpressure: enqReady drops when DEPTH lines are held (no same-cycle pop bypass); deqReady=0 stalls.
// Ports: clk/rst_n clock and async active-low reset; flush discards everything queued;
//        enqValid/enqReady/enqPc/enqLine/enqFault line input; deqValid/deqReady/deqPc/
//        deqInsn/deqFault word output; occupancy = number of lines held.
module fetch_queue
  import FetchQueueTypes::*;
#(
  parameter int DEPTH      = 4,
  parameter int LINE_WIDTH = 128,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       enqValid,
  output logic                       enqReady,
  input  logic [ADDR_WIDTH-1:0]      enqPc,
  input  logic [LINE_WIDTH-1:0]      enqLine,
  input  logic                       enqFault,
  output logic                       deqValid,
  input  logic                       deqReady,
  output logic [ADDR_WIDTH-1:0]      deqPc,
  output logic [INSN_WIDTH-1:0]      deqInsn,
  output logic                       deqFault,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int WORDS = LINE_WIDTH / INSN_WIDTH;
  localparam int OFFW  = $clog2(WORDS);
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH+1);
  localparam int EW    = ADDR_WIDTH + LINE_WIDTH + 1;

  logic [PW-1:0]         head, tail;
  logic [CW-1:0]         count;
  logic                  headFirst;
  logic [OFFW-1:0]       wordIdx;

  logic [EW-1:0]         headEntry;
  logic [ADDR_WIDTH-1:0] headPc;
  logic [LINE_WIDTH-1:0] headLine;
  logic                  headFault;

  logic [OFFW-1:0]       curIdx;
  logic                  isLastWord;
  logic                  enqFire, deqFire, popFire;
  logic [ADDR_WIDTH-1:0] pcOut;

  fetch_queue_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (enqFire),
    .waddr (tail),
    .wdata ({enqPc, enqLine, enqFault}),
    .raddr (head),
    .rdata (headEntry)
  );

  assign {headPc, headLine, headFault} = headEntry;

  // The first word served from an entry comes from its PC offset; later
  // words come from the running index.
  assign curIdx     = headFirst ? headPc[OFFW+1:2] : wordIdx;
  assign isLastWord = (curIdx == OFFW'(WORDS-1));

  assign enqReady = (count != CW'(DEPTH));
  assign deqValid = (count != '0);

  // Flush suppresses both handshakes so neither can disturb the cleared state.
  assign enqFire = enqValid && enqReady && !flush;
  assign deqFire = deqValid && deqReady && !flush;
  // A faulting entry carries no usable words, so it leaves after one handshake.
  assign popFire = deqFire && (headFault || isLastWord);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      headFirst <= 1'b1;
      wordIdx   <= '0;
    end else if (flush) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      headFirst <= 1'b1;
      wordIdx   <= '0;
    end else begin
      if (enqFire) begin
        tail <= tail + 1'b1;
      end
      if (popFire) begin
        head <= head + 1'b1;
      end
      count <= count + CW'(enqFire) - CW'(popFire);
      if (popFire) begin
        headFirst <= 1'b1;
        wordIdx   <= '0;
      end else if (deqFire) begin
        headFirst <= 1'b0;
        wordIdx   <= curIdx + 1'b1;
      end
    end
  end

  always_comb begin
    pcOut            = headPc;
    pcOut[OFFW+1:2]  = curIdx;
    pcOut[1:0]       = 2'b00;
  end

  assign deqPc     = pcOut;
  assign deqInsn   = line_word(MAX_LINE_WIDTH'(headLine), 32'(curIdx));
  assign deqFault  = headFault;
  assign occupancy = count;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic         clk;
  logic         rst_n;
  logic         flush;
  logic         enqValid;
  logic         enqReady;
  logic [31:0]  enqPc;
  logic [127:0] enqLine;
  logic         enqFault;
  logic         deqValid;
  logic         deqReady;
  logic [31:0]  deqPc;
  logic [31:0]  deqInsn;
  logic         deqFault;
  logic [2:0]   occupancy;

  fetch_queue #(.DEPTH(DEPTH), .LINE_WIDTH(128), .ADDR_WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .enqValid  (enqValid),
    .enqReady  (enqReady),
    .enqPc     (enqPc),
    .enqLine   (enqLine),
    .enqFault  (enqFault),
    .deqValid  (deqValid),
    .deqReady  (deqReady),
    .deqPc     (deqPc),
    .deqInsn   (deqInsn),
    .deqFault  (deqFault),
    .occupancy (occupancy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: the stream of words still to be delivered, in order,
  // each tagged with whether it is the last word of its line.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
    logic        fault;
    logic        last;
  } word_t;

  word_t mq[$];
  int    lines;
  int    n_checks;
  int    n_fail;

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void model_enq(input logic [31:0] pc, input logic [127:0] line, input logic fault);
    int off;
    word_t w;
    off = int'(pc[3:2]);
    if (fault) begin
      w.pc = pc & 32'hFFFF_FFFC;
      w.insn = line[32*off +: 32];
      w.fault = 1'b1;
      w.last = 1'b1;
      mq.push_back(w);
    end else begin
      for (int i = off; i < 4; i++) begin
        w.pc = (pc & 32'hFFFF_FFF0) | 32'(i * 4);
        w.insn = line[32*i +: 32];
        w.fault = 1'b0;
        w.last = (i == 3);
        mq.push_back(w);
      end
    end
    lines++;
  endfunction

  function automatic void check_model();
    chk("deqValid", deqValid, (mq.size() != 0));
    chk("enqReady", enqReady, (lines != DEPTH));
    chk("occupancy", occupancy, lines);
    if (mq.size() != 0) begin
      chk("deqPc", deqPc, mq[0].pc);
      chk("deqInsn", deqInsn, mq[0].insn);
      chk("deqFault", deqFault, mq[0].fault);
    end
  endfunction

  // One clock cycle: drive inputs after the falling edge, predict the edge,
  // then compare the DUT at the next falling edge.
  task automatic cyc(input logic f, input logic ev, input logic [31:0] pc,
                     input logic [127:0] ln, input logic flt, input logic dr);
    logic enq_ok, deq_ok;
    word_t w;
    flush = f; enqValid = ev; enqPc = pc; enqLine = ln; enqFault = flt; deqReady = dr;
    enq_ok = ev && (lines != DEPTH) && !f;
    deq_ok = dr && (mq.size() != 0) && !f;
    @(posedge clk);
    if (f) begin
      mq.delete();
      lines = 0;
    end else begin
      if (deq_ok) begin
        w = mq.pop_front();
        if (w.last) lines--;
      end
      if (enq_ok) model_enq(pc, ln, flt);
    end
    @(negedge clk);
    check_model();
  endtask

  function automatic logic [127:0] rline();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [127:0] L0, L5;

  initial begin
    n_checks = 0; n_fail = 0; lines = 0;
    rst_n = 1'b0; flush = 1'b0; enqValid = 1'b0; enqPc = '0; enqLine = '0;
    enqFault = 1'b0; deqReady = 1'b0;
    #2;
    chk("rst_deqValid", deqValid, 1'b0);
    chk("rst_enqReady", enqReady, 1'b1);
    chk("rst_occupancy", occupancy, 3'd0);
    chk("rst_deqPc", deqPc, 32'h0);
    chk("rst_deqInsn", deqInsn, 32'h0);
    chk("rst_deqFault", deqFault, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: aligned line
    L0 = {32'h44, 32'h33, 32'h22, 32'h11};
    cyc(0, 1, 32'h1000, L0, 0, 0);
    chk("t1_pc0", deqPc, 32'h1000);
    chk("t1_insn0", deqInsn, 32'h11);
    cyc(0, 0, 0, 0, 0, 1);
    chk("t1_pc1", deqPc, 32'h1004);
    cyc(0, 0, 0, 0, 0, 1);
    chk("t1_pc2", deqPc, 32'h1008);
    chk("t1_insn2", deqInsn, 32'h33);
    cyc(0, 0, 0, 0, 0, 1);
    chk("t1_pc3", deqPc, 32'h100C);
    chk("t1_insn3", deqInsn, 32'h44);
    cyc(0, 0, 0, 0, 0, 1);
    chk("t1_empty", deqValid, 1'b0);
    chk("t1_occ", occupancy, 3'd0);

    // 2: misaligned start
    L0 = {32'hD, 32'hC, 32'hB, 32'hA};
    cyc(0, 1, 32'h2008, L0, 0, 0);
    chk("t2_pc0", deqPc, 32'h2008);
    chk("t2_insn0", deqInsn, 32'hC);
    cyc(0, 0, 0, 0, 0, 1);
    chk("t2_pc1", deqPc, 32'h200C);
    chk("t2_occ1", occupancy, 3'd1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("t2_empty", deqValid, 1'b0);

    // 3: faulting fetch delivers a single word
    cyc(0, 1, 32'h3004, rline(), 1, 0);
    cyc(0, 1, 32'h3100, {32'h4, 32'h3, 32'h2, 32'h1}, 0, 0);
    chk("t3_pc0", deqPc, 32'h3004);
    chk("t3_fault0", deqFault, 1'b1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("t3_pc1", deqPc, 32'h3100);
    chk("t3_fault1", deqFault, 1'b0);
    chk("t3_insn1", deqInsn, 32'h1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 1);
    chk("t3_empty", deqValid, 1'b0);

    // 4: full, stall, no full-bypass, pointer wrap
    for (int i = 0; i < 4; i++) cyc(0, 1, 32'h600C + 32'(i * 32'h100), rline(), 0, 0);
    chk("t4_occ_full", occupancy, 3'd4);
    chk("t4_rdy_full", enqReady, 1'b0);
    L5 = {32'h5555_0003, 32'h5555_0002, 32'h5555_0001, 32'h5555_0000};
    cyc(0, 1, 32'h640C, L5, 0, 0);
    chk("t4_held", occupancy, 3'd4);
    cyc(0, 1, 32'h640C, L5, 0, 1);
    chk("t4_after_pop_occ", occupancy, 3'd3);
    chk("t4_after_pop_rdy", enqReady, 1'b1);
    cyc(0, 1, 32'h640C, L5, 0, 0);
    chk("t4_refill", occupancy, 3'd4);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1);
    chk("t4_wrap_pc", deqPc, 32'h640C);
    chk("t4_wrap_insn", deqInsn, 32'h5555_0003);
    cyc(0, 0, 0, 0, 0, 1);
    chk("t4_empty", deqValid, 1'b0);

    // 5: flush mid-line with a same-cycle enqueue
    cyc(0, 1, 32'h1000, rline(), 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("t5_mid_pc", deqPc, 32'h1008);
    cyc(1, 1, 32'h5000, rline(), 0, 1);
    chk("t5_occ", occupancy, 3'd0);
    chk("t5_valid", deqValid, 1'b0);
    cyc(0, 1, 32'h4004, rline(), 0, 0);
    chk("t5_next_pc", deqPc, 32'h4004);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1);
    chk("t5_empty", deqValid, 1'b0);

    // 6: asynchronous reset between edges
    for (int i = 0; i < 3; i++) cyc(0, 1, 32'h7000 + 32'(i * 16), rline(), 0, 0);
    chk("t6_occ3", occupancy, 3'd3);
    enqValid = 1'b0; deqReady = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid", deqValid, 1'b0);
    chk("t6_occ", occupancy, 3'd0);
    chk("t6_rdy", enqReady, 1'b1);
    mq.delete();
    lines = 0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 1, 32'h8000, {32'h8, 32'h7, 32'h6, 32'h5}, 0, 0);
    chk("t6_resume_pc", deqPc, 32'h8000);
    chk("t6_resume_insn", deqInsn, 32'h5);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(0, 31) == 0), ($urandom_range(0, 1) == 1),
          $urandom, rline(), ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0));
    end
    for (int n = 0; n < 20; n++) cyc(0, 0, 0, 0, 0, 1);
    chk("final_empty", deqValid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
